// File: rtl/count_pulse_gen_if.sv
// count_pulse_gen_if
//   Groups the button-conditioner signals into one bundle.
//   master : drives the raw inputs (btn_in, dir_in, repeat_en), observes outputs
//   slave  : the conditioner; consumes raw inputs, drives inc/up_down_sel/pressed
//   btn_in      raw asynchronous button, high = pressed
//   dir_in      raw asynchronous direction switch, 1 = down
//   repeat_en   synchronous auto-repeat enable
//   inc         single-cycle count impulse
//   up_down_sel registered direction, frozen during a press
//   pressed     high while the button is accepted as held
interface count_pulse_gen_if;
    logic btn_in;
    logic dir_in;
    logic repeat_en;
    logic inc;
    logic up_down_sel;
    logic pressed;

    modport master (
        output btn_in,
        output dir_in,
        output repeat_en,
        input  inc,
        input  up_down_sel,
        input  pressed
    );

    modport slave (
        input  btn_in,
        input  dir_in,
        input  repeat_en,
        output inc,
        output up_down_sel,
        output pressed
    );
endinterface

// File: rtl/count_pulse_gen.sv
// count_pulse_gen
//   Turns a bouncy push-button and a raw direction switch into clean
//   single-cycle inc pulses and a stable up_down_sel for the counter,
//   with optional auto-repeat while the button is held.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    count_pulse_gen_if.slave (btn_in, dir_in, repeat_en in;
//            inc, up_down_sel, pressed out)
//   All outputs are registered.
module count_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int TIMER_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    count_pulse_gen_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DEB_PRESS = 3'd1;
    localparam logic [2:0] HELD      = 3'd2;
    localparam logic [2:0] REPEAT    = 3'd3;
    localparam logic [2:0] DEB_REL   = 3'd4;

    localparam logic [TIMER_W-1:0] DEB_LAST    = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 samples the pin, the top bit is used.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] btn_sync_reg;
    logic [SYNC_STAGES-1:0] dir_sync_reg;
    logic                   btn_s;
    logic                   dir_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_reg <= '0;
            dir_sync_reg <= '0;
        end else begin
            btn_sync_reg <= {btn_sync_reg[SYNC_STAGES-2:0], bus.btn_in};
            dir_sync_reg <= {dir_sync_reg[SYNC_STAGES-2:0], bus.dir_in};
        end
    end

    assign btn_s = btn_sync_reg[SYNC_STAGES-1];
    assign dir_s = dir_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM and shared timer
    // ------------------------------------------------------------------
    logic [2:0]         state_reg;
    logic [2:0]         state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic               inc_reg;
    logic               inc_next;
    logic               up_down_sel_reg;
    logic               pressed_reg;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        inc_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_s) begin
                    state_next = DEB_PRESS;
                    timer_next = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer_reg == DEB_LAST) begin
                    state_next = HELD;
                    inc_next   = 1'b1;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TIMER_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = DEB_REL;
                    timer_next = '0;
                end else if (bus.repeat_en && (timer_reg >= DELAY_LAST) && !inc_reg) begin
                    // !inc_reg keeps pulses apart when REPEAT_DELAY is 1
                    state_next = REPEAT;
                    inc_next   = 1'b1;
                    timer_next = '0;
                end else if (timer_reg < DELAY_LAST) begin
                    // Saturate so a late repeat_en fires on the next edge
                    timer_next = timer_reg + TIMER_ONE;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_next = DEB_REL;
                    timer_next = '0;
                end else if (!bus.repeat_en) begin
                    // Pause: timer holds, pulsing resumes from here
                    timer_next = timer_reg;
                end else if (timer_reg == PERIOD_LAST) begin
                    // With REPEAT_PERIOD = 1 the guard stretches the period
                    // to two cycles so inc never stays high back to back.
                    if (!inc_reg) begin
                        inc_next   = 1'b1;
                        timer_next = '0;
                    end
                end else begin
                    timer_next = timer_reg + TIMER_ONE;
                end
            end
            DEB_REL: begin
                if (btn_s) begin
                    // Bounce during release restarts the quiet window
                    timer_next = '0;
                end else if (timer_reg == DEB_LAST) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TIMER_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            inc_reg         <= 1'b0;
            up_down_sel_reg <= 1'b0;
            pressed_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            inc_reg     <= inc_next;
            pressed_reg <= (state_next == HELD) || (state_next == REPEAT);
            // Direction tracks the switch only while idle, so it is frozen
            // for the whole press / repeat burst.
            if (state_reg == IDLE) begin
                up_down_sel_reg <= dir_s;
            end
        end
    end

    assign bus.inc         = inc_reg;
    assign bus.up_down_sel = up_down_sel_reg;
    assign bus.pressed     = pressed_reg;

endmodule
